data_path_gen: RTL and testbench

Parametrised successor to the 8-bit CPU data path. It provides a WIDTH-bit datapath with an NREGS-entry general register file in place of fixed A/B, plus PC, MAR, IR, MDR and CCR. Memory access goes through a wait-state-tolerant req/ack handshake that stalls the datapath. It sits between the control unit, which drives the control strobes, and the memory.

---
 rtl/data_path_gen_if.sv | 22 ++
 rtl/data_path_gen.sv | 162 ++++++++++++++++
 tb/tb_data_path_gen.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_path_gen_if.sv
// Memory-side req/ack bus of the parametrised data path.
// The master drives address, data and request; the slave answers with ack and read data.
interface data_path_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             mem_req;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_req,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_req,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_path_gen.sv
// WIDTH-bit CPU data path with an NREGS-entry register file, PC/MAR/IR/MDR/CCR,
// and a wait-state-tolerant memory handshake that stalls all register updates.
module data_path_gen #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int RSEL  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_load,
    input  logic            mar_load,
    input  logic            pc_load,
    input  logic            pc_inc,
    input  logic            rf_we,
    input  logic [RSEL-1:0] rf_wsel,
    input  logic [RSEL-1:0] rf_asel,
    input  logic [RSEL-1:0] rf_bsel,
    input  logic [2:0]      alu_sel,
    input  logic            ccr_load,
    input  logic [1:0]      from_sel,
    input  logic [1:0]      to_sel,
    input  logic            mem_rd,
    input  logic            mem_wr,
    output logic [WIDTH-1:0] ir,
    output logic [3:0]      ccr,
    output logic            busy,
    data_path_gen_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, mar_q, mar_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [3:0]       ccr_q, ccr_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];

    logic [WIDTH-1:0] reg_a, reg_b, to_bus, from_bus, alu_res;
    logic [WIDTH:0]   alu_ext;
    logic             flag_v;

    assign reg_a = rf_q[rf_asel];
    assign reg_b = rf_q[rf_bsel];

    // Logic ops are zero-extended so alu_ext[WIDTH] doubles as carry/borrow for every op.
    always_comb begin
        alu_ext = '0;
        flag_v  = 1'b0;
        unique case (alu_sel)
            3'b000: alu_ext = {1'b0, reg_a} + {1'b0, reg_b};
            3'b001: alu_ext = {1'b0, reg_a} - {1'b0, reg_b};
            3'b010: alu_ext = {1'b0, reg_a & reg_b};
            3'b011: alu_ext = {1'b0, reg_a | reg_b};
            3'b100: alu_ext = {1'b0, reg_a ^ reg_b};
            3'b101: alu_ext = {1'b0, ~reg_a};
            3'b110: alu_ext = {1'b0, reg_a} + (WIDTH+1)'(1);
            default: alu_ext = {1'b0, reg_a} - (WIDTH+1)'(1);
        endcase
        alu_res = alu_ext[WIDTH-1:0];
        unique case (alu_sel)
            3'b000: flag_v = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (alu_res[WIDTH-1] != reg_a[WIDTH-1]);
            3'b001: flag_v = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (alu_res[WIDTH-1] != reg_a[WIDTH-1]);
            3'b110: flag_v = !reg_a[WIDTH-1] && alu_res[WIDTH-1];
            3'b111: flag_v = reg_a[WIDTH-1] && !alu_res[WIDTH-1];
            default: flag_v = 1'b0;
        endcase
    end

    always_comb begin
        unique case (to_sel)
            2'b00:   to_bus = pc_q;
            2'b01:   to_bus = reg_a;
            2'b10:   to_bus = reg_b;
            default: to_bus = mar_q;
        endcase
        unique case (from_sel)
            2'b00:   from_bus = alu_res;
            2'b01:   from_bus = to_bus;
            2'b10:   from_bus = mdr_q;
            default: from_bus = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        ccr_d   = ccr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rf_d    = rf_q;

        if (state_q == IDLE) begin
            if (ir_load)  ir_d  = from_bus;
            if (mar_load) mar_d = from_bus;
            if (pc_load)       pc_d = from_bus;
            else if (pc_inc)   pc_d = pc_q + 1'b1;
            if (rf_we)    rf_d[rf_wsel] = from_bus;
            if (ccr_load) ccr_d = {alu_res[WIDTH-1], alu_res == '0, flag_v, alu_ext[WIDTH]};
        end

        unique case (state_q)
            IDLE: begin
                if (mem_wr) begin
                    state_d = REQ;
                    addr_d  = mar_q;
                    we_d    = 1'b1;
                    wdata_d = to_bus;
                end else if (mem_rd) begin
                    state_d = REQ;
                    addr_d  = mar_q;
                    we_d    = 1'b0;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    if (!we_q) mdr_d = mem.mem_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            ccr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            ccr_q   <= ccr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rf_q    <= rf_d;
        end
    end

    assign ir            = ir_q;
    assign ccr           = ccr_q;
    assign busy          = (state_q != IDLE);
    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
endmodule

// File: tb/tb_data_path_gen.sv
// Scoreboard bench: an 8-bit/4-reg and a 16-bit/8-reg instance run in lockstep on shared
// control strobes; expectations are queued by the stimulus and popped by independent monitors.
module tb_data_path_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       ir_load, mar_load, pc_load, pc_inc, rf_we, ccr_load, mem_rd, mem_wr;
    logic [2:0] wsel, asel, bsel, alu_sel;
    logic [1:0] from_sel, to_sel;
    logic [7:0]  ir8;
    logic [15:0] ir16;
    logic [3:0]  ccr8, ccr16;
    logic        busy8, busy16;

    data_path_gen_if #(.WIDTH(8))  m8 ();
    data_path_gen_if #(.WIDTH(16)) m16 ();

    data_path_gen #(.WIDTH(8), .NREGS(4)) dut8 (
        .clk(clk), .reset(reset), .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load),
        .pc_inc(pc_inc), .rf_we(rf_we), .rf_wsel(wsel[1:0]), .rf_asel(asel[1:0]),
        .rf_bsel(bsel[1:0]), .alu_sel(alu_sel), .ccr_load(ccr_load), .from_sel(from_sel),
        .to_sel(to_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir(ir8), .ccr(ccr8),
        .busy(busy8), .mem(m8)
    );

    data_path_gen #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load),
        .pc_inc(pc_inc), .rf_we(rf_we), .rf_wsel(wsel), .rf_asel(asel),
        .rf_bsel(bsel), .alu_sel(alu_sel), .ccr_load(ccr_load), .from_sel(from_sel),
        .to_sel(to_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir(ir16), .ccr(ccr16),
        .busy(busy16), .mem(m16)
    );

    int checks = 0;
    int errors = 0;

    localparam int K_IR8 = 0, K_IR16 = 1, K_CCR8 = 2, K_CCR16 = 3, K_BUSY = 4, K_REQ = 5,
                   K_ADDR8 = 6, K_ADDR16 = 7;

    typedef struct {
        string       nm;
        int          kind;
        logic [15:0] exp;
    } obs_t;

    typedef struct {
        string       nm;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } mexp_t;

    obs_t  obs_q[$];
    mexp_t mem_q[$];
    logic  obs_req = 1'b0;

    logic [15:0] mar_exp;
    logic [15:0] rdata_v;
    int          ack_delay;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_IR8:    return {8'h00, ir8};
            K_IR16:   return ir16;
            K_CCR8:   return {12'h000, ccr8};
            K_CCR16:  return {12'h000, ccr16};
            K_BUSY:   return {14'h0000, busy16, busy8};
            K_REQ:    return {14'h0000, m16.mem_req, m8.mem_req};
            K_ADDR8:  return {8'h00, m8.mem_addr};
            default:  return m16.mem_addr;
        endcase
    endfunction

    // Observation monitor: drains all queued expectations whenever a sample is requested.
    always @(negedge clk) begin
        if (obs_req) begin
            while (obs_q.size() > 0) begin
                obs_t o;
                o = obs_q.pop_front();
                chk(o.nm, actual(o.kind), o.exp);
            end
        end
    end

    // Memory monitor: checks hold-stability during REQ and pops one record per completed transfer.
    int          rcnt = 0;
    logic [7:0]  s_addr, s_wdata;
    logic        s_we;
    always @(negedge clk) begin
        if (m8.mem_req) begin
            if (rcnt == 0) begin
                s_addr  = m8.mem_addr;
                s_wdata = m8.mem_wdata;
                s_we    = m8.mem_we;
            end else begin
                chk("req_hold", {m8.mem_we, m8.mem_wdata, m8.mem_addr},
                    {s_we, s_wdata, s_addr});
            end
            rcnt++;
            chk("busy_in_req", {15'h0, busy8}, 16'h1);
            if (m8.mem_ack) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 16'(rcnt), 16'h0);
                end else begin
                    mexp_t e;
                    e = mem_q.pop_front();
                    chk({e.nm, "_addr8"},  {8'h00, m8.mem_addr}, {8'h00, e.addr[7:0]});
                    chk({e.nm, "_addr16"}, m16.mem_addr, e.addr);
                    chk({e.nm, "_we"},     {14'h0, m16.mem_we, m8.mem_we}, {14'h0, e.we, e.we});
                    chk({e.nm, "_cycles"}, 16'(rcnt), 16'(e.cyc));
                    if (e.we) begin
                        chk({e.nm, "_wdata8"},  {8'h00, m8.mem_wdata}, {8'h00, e.wdata[7:0]});
                        chk({e.nm, "_wdata16"}, m16.mem_wdata, e.wdata);
                    end
                end
            end
        end else begin
            rcnt = 0;
        end
    end

    // Memory slave: acks in the ack_delay-th REQ cycle, shared by both instances.
    initial begin
        int scnt;
        logic ack;
        scnt = 0;
        ack  = 1'b0;
        m8.mem_ack = 1'b0;  m16.mem_ack = 1'b0;
        m8.mem_rdata = '0;  m16.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (m8.mem_req) begin
                scnt++;
                ack = (scnt == ack_delay);
            end else begin
                scnt = 0;
                ack  = 1'b0;
            end
            m8.mem_ack    = ack;
            m16.mem_ack   = ack;
            m8.mem_rdata  = rdata_v[7:0];
            m16.mem_rdata = rdata_v;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0; rf_we = 0; ccr_load = 0;
        mem_rd = 0; mem_wr = 0; wsel = 0; asel = 0; bsel = 0; alu_sel = 0;
        from_sel = 0; to_sel = 0;
    endtask

    task automatic push(input string nm, input int kind, input logic [15:0] exp);
        obs_t o;
        o.nm = nm; o.kind = kind; o.exp = exp;
        obs_q.push_back(o);
    endtask

    task automatic push_mem(input string nm, input logic we, input logic [15:0] wd, input int cyc);
        mexp_t e;
        e.nm = nm; e.we = we; e.addr = mar_exp; e.wdata = wd; e.cyc = cyc;
        mem_q.push_back(e);
    endtask

    task automatic sample();
        obs_req = 1'b1;
        @(negedge clk);
        #1;
        obs_req = 1'b0;
    endtask

    task automatic load_reg(input int r, input logic [15:0] v);
        rdata_v = v; ack_delay = 1;
        push_mem($sformatf("ld_r%0d", r), 1'b0, 16'h0, 1);
        mem_rd = 1; tick();
        mem_rd = 0; tick(); tick();
        from_sel = 2'b10; rf_we = 1; wsel = 3'(r); tick();
        idle_ctl();
    endtask

    task automatic read_reg_ir(input int r);
        to_sel = 2'b01; asel = 3'(r); from_sel = 2'b01; ir_load = 1; tick();
        idle_ctl();
    endtask

    task automatic expect_ir(input string nm, input logic [7:0] e8, input logic [15:0] e16);
        push({nm, "_ir8"}, K_IR8, {8'h00, e8});
        push({nm, "_ir16"}, K_IR16, e16);
    endtask

    task automatic expect_ccr(input string nm, input logic [3:0] e8, input logic [3:0] e16);
        push({nm, "_ccr8"}, K_CCR8, {12'h0, e8});
        push({nm, "_ccr16"}, K_CCR16, {12'h0, e16});
    endtask

    task automatic expect_reset_state(input string nm);
        expect_ir(nm, 8'h00, 16'h0000);
        expect_ccr(nm, 4'h0, 4'h0);
        push({nm, "_busy"}, K_BUSY, 16'h0);
        push({nm, "_req"}, K_REQ, 16'h0);
        push({nm, "_addr8"}, K_ADDR8, 16'h0);
        push({nm, "_addr16"}, K_ADDR16, 16'h0);
    endtask

    initial begin
        reset = 0; idle_ctl(); mar_exp = 16'h0; rdata_v = 16'h0; ack_delay = 1;
        repeat (3) tick();
        expect_reset_state("rst");
        sample();
        reset = 1;
        tick();

        // ALU add overflow, sub borrow, and/xor/inc
        load_reg(0, 16'h007F); load_reg(1, 16'h0001);
        asel = 0; bsel = 1; alu_sel = 3'b000; ccr_load = 1; rf_we = 1; wsel = 2; tick(); idle_ctl();
        expect_ccr("add", 4'b1010, 4'b0000); sample();
        read_reg_ir(2); expect_ir("add", 8'h80, 16'h0080); sample();

        load_reg(0, 16'h0000);
        asel = 0; bsel = 1; alu_sel = 3'b001; ccr_load = 1; rf_we = 1; wsel = 3; tick(); idle_ctl();
        expect_ccr("sub", 4'b1001, 4'b1001); sample();
        read_reg_ir(3); expect_ir("sub", 8'hFF, 16'hFFFF); sample();

        load_reg(0, 16'h00F0); load_reg(1, 16'h000F);
        asel = 0; bsel = 1; alu_sel = 3'b010; ccr_load = 1; ir_load = 1; tick(); idle_ctl();
        expect_ccr("and", 4'b0100, 4'b0100); expect_ir("and", 8'h00, 16'h0000); sample();

        asel = 3; alu_sel = 3'b110; ccr_load = 1; ir_load = 1; tick(); idle_ctl();
        expect_ccr("inc", 4'b0101, 4'b0101); expect_ir("inc", 8'h00, 16'h0000); sample();

        asel = 0; bsel = 1; alu_sel = 3'b100; ccr_load = 1; ir_load = 1; tick(); idle_ctl();
        expect_ccr("xor", 4'b1000, 4'b0000); expect_ir("xor", 8'hFF, 16'h00FF); sample();

        // PC wrap and load-over-increment priority
        load_reg(0, 16'hFFFF);
        to_sel = 2'b01; asel = 0; from_sel = 2'b01; pc_load = 1; tick(); idle_ctl();
        pc_inc = 1; tick(); idle_ctl();
        to_sel = 2'b00; from_sel = 2'b01; ir_load = 1; tick(); idle_ctl();
        expect_ir("pc_wrap", 8'h00, 16'h0000); sample();
        load_reg(1, 16'h0042);
        to_sel = 2'b01; asel = 1; from_sel = 2'b01; pc_load = 1; pc_inc = 1; tick(); idle_ctl();
        to_sel = 2'b00; from_sel = 2'b01; ir_load = 1; tick(); idle_ctl();
        expect_ir("pc_prio", 8'h42, 16'h0042); sample();

        // Wait-stated read with an ir_load attempted while busy
        load_reg(2, 16'h0010);
        to_sel = 2'b01; asel = 2; from_sel = 2'b01; mar_load = 1; tick(); idle_ctl();
        mar_exp = 16'h0010;
        ack_delay = 3; rdata_v = 16'h00A5;
        push_mem("rd_a5", 1'b0, 16'h0, 3);
        mem_rd = 1; tick();
        mem_rd = 0; from_sel = 2'b11; ir_load = 1;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("rd_busy%0d", i), K_BUSY, 16'h3);
            sample();
            tick();
        end
        idle_ctl();
        expect_ir("rd_ir_ignored", 8'h42, 16'h0042);
        push("rd_idle_busy", K_BUSY, 16'h0);
        sample();
        from_sel = 2'b10; ir_load = 1; tick(); idle_ctl();
        expect_ir("rd_mdr", 8'hA5, 16'h00A5); sample();

        // Simultaneous wr+rd: write wins, wdata held though the to-bus changes
        load_reg(0, 16'h003C);
        ack_delay = 2;
        push_mem("wr_3c", 1'b1, 16'h003C, 2);
        mem_wr = 1; mem_rd = 1; to_sel = 2'b01; asel = 0; tick();
        mem_wr = 0; mem_rd = 0; asel = 1;
        tick(); tick(); tick(); idle_ctl();

        // Asynchronous reset in the middle of a request
        ack_delay = 5;
        mem_rd = 1; tick(); mem_rd = 0;
        push("mid_req", K_REQ, 16'h3); push("mid_busy", K_BUSY, 16'h3); sample();
        reset = 0; #1;
        expect_reset_state("mid_rst");
        sample();
        reset = 1; mar_exp = 16'h0;
        tick();
        read_reg_ir(0); expect_ir("rst_r0", 8'h00, 16'h0000); sample();
        from_sel = 2'b10; ir_load = 1; tick(); idle_ctl();
        expect_ir("rst_mdr", 8'h00, 16'h0000); sample();
        to_sel = 2'b00; from_sel = 2'b01; ir_load = 1; tick(); idle_ctl();
        expect_ir("rst_pc", 8'h00, 16'h0000); sample();

        // Highest register as destination (R7 on the 16-bit instance)
        load_reg(0, 16'h007F); load_reg(1, 16'h0001);
        asel = 0; bsel = 1; alu_sel = 3'b000; ccr_load = 1; rf_we = 1; wsel = 7; tick(); idle_ctl();
        expect_ccr("r7_add", 4'b1010, 4'b0000); sample();
        read_reg_ir(7); expect_ir("r7_add", 8'h80, 16'h0080); sample();

        tick();
        chk("mem_q_drained", 16'(mem_q.size()), 16'h0);
        chk("obs_q_drained", 16'(obs_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
